pipe_control: RTL and testbench



---
 rtl/pipe_control.sv | 261 ++++++++++++++++++++++++++
 tb/tb_pipe_control.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control.sv
// pipe_control: pipelined control unit for the five-stage RV32I core.
// Decodes opcode/funct fields in ID, carries the control word through
// ID/EX, EX/MEM and MEM/WB, and resolves branches/jumps in EX from ALU flags.
module pipe_control #(
  parameter int ALUCTRL_W = 4,
  parameter int ADDR_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op_d,
  input  logic [2:0]           funct3_d,
  input  logic [6:0]           funct7_d,
  input  logic                 flush_e,
  input  logic                 zero_e,
  input  logic                 lt_e,
  input  logic                 ltu_e,
  output logic [2:0]           ImmSrc_d,
  output logic                 illegal_d,
  output logic [ALUCTRL_W-1:0] ALUControl_e,
  output logic                 ALUSrc_e,
  output logic                 ASrcPC_e,
  output logic [1:0]           PCSrc_e,
  output logic                 taken_e,
  output logic                 MemRead_e,
  output logic                 MemWrite_m,
  output logic [ADDR_W-1:0]    AddressingControl_m,
  output logic                 RegWrite_m,
  output logic                 RegWrite_w,
  output logic [1:0]           ResultSrc_w,
  output logic                 illegal_w
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD   = ALUCTRL_W'(4'd0);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB   = ALUCTRL_W'(4'd1);
  localparam logic [ALUCTRL_W-1:0] ALU_AND   = ALUCTRL_W'(4'd2);
  localparam logic [ALUCTRL_W-1:0] ALU_OR    = ALUCTRL_W'(4'd3);
  localparam logic [ALUCTRL_W-1:0] ALU_XOR   = ALUCTRL_W'(4'd4);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT   = ALUCTRL_W'(4'd5);
  localparam logic [ALUCTRL_W-1:0] ALU_SLTU  = ALUCTRL_W'(4'd6);
  localparam logic [ALUCTRL_W-1:0] ALU_SLL   = ALUCTRL_W'(4'd7);
  localparam logic [ALUCTRL_W-1:0] ALU_SRL   = ALUCTRL_W'(4'd8);
  localparam logic [ALUCTRL_W-1:0] ALU_SRA   = ALUCTRL_W'(4'd9);
  localparam logic [ALUCTRL_W-1:0] ALU_PASSB = ALUCTRL_W'(4'd10);

  // Full control word held in ID/EX; later stages keep only what they use.
  typedef struct packed {
    logic                 illegal;
    logic                 reg_write;
    logic [1:0]           result_src;
    logic                 mem_write;
    logic                 mem_read;
    logic                 branch;
    logic [1:0]           jump;
    logic [ALUCTRL_W-1:0] alu_control;
    logic                 alu_src;
    logic                 a_src_pc;
    logic [2:0]           funct3;
  } ex_word_t;

  typedef struct packed {
    logic       illegal;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [2:0] funct3;
  } mem_word_t;

  typedef struct packed {
    logic       illegal;
    logic       reg_write;
    logic [1:0] result_src;
  } wb_word_t;

  // Map funct3 (plus the alternate-op bit) onto an ALU code.
  function automatic logic [ALUCTRL_W-1:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_from_f3 = ALU_SLL;
      3'b010:  alu_from_f3 = ALU_SLT;
      3'b011:  alu_from_f3 = ALU_SLTU;
      3'b100:  alu_from_f3 = ALU_XOR;
      3'b101:  alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_from_f3 = ALU_OR;
      3'b111:  alu_from_f3 = ALU_AND;
      default: alu_from_f3 = ALU_ADD;
    endcase
  endfunction

  ex_word_t  word;
  ex_word_t  dec;
  logic      bad;
  ex_word_t  id_ex;
  mem_word_t ex_mem;
  wb_word_t  mem_wb;
  logic      cond;

  // ID decode: build the control word, then swap in a marked bubble if illegal.
  always_comb begin
    word        = '0;
    word.funct3 = funct3_d;
    bad         = 1'b0;
    ImmSrc_d    = 3'b000;
    case (op_d)
      OP_R: begin
        bad = !((funct7_d == F7_BASE) ||
                ((funct7_d == F7_ALT) && ((funct3_d == 3'b000) || (funct3_d == 3'b101))));
        word.reg_write   = 1'b1;
        word.alu_control = alu_from_f3(funct3_d, funct7_d == F7_ALT);
      end
      OP_I: begin
        if (funct3_d == 3'b001) begin
          bad = (funct7_d != F7_BASE);
        end else if (funct3_d == 3'b101) begin
          bad = !((funct7_d == F7_BASE) || (funct7_d == F7_ALT));
        end else begin
          bad = 1'b0;
        end
        word.reg_write   = 1'b1;
        word.alu_src     = 1'b1;
        word.alu_control = alu_from_f3(funct3_d, (funct3_d == 3'b101) && (funct7_d == F7_ALT));
      end
      OP_LOAD: begin
        bad = (funct3_d == 3'b011) || (funct3_d == 3'b110) || (funct3_d == 3'b111);
        word.reg_write  = 1'b1;
        word.alu_src    = 1'b1;
        word.mem_read   = 1'b1;
        word.result_src = 2'b01;
      end
      OP_STORE: begin
        ImmSrc_d = 3'b001;
        bad = funct3_d[2] || (funct3_d[1:0] == 2'b11);
        word.alu_src   = 1'b1;
        word.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        ImmSrc_d = 3'b010;
        bad = (funct3_d == 3'b010) || (funct3_d == 3'b011);
        word.branch      = 1'b1;
        word.alu_control = ALU_SUB;
      end
      OP_JAL: begin
        ImmSrc_d = 3'b011;
        word.reg_write  = 1'b1;
        word.jump       = 2'b01;
        word.result_src = 2'b10;
      end
      OP_JALR: begin
        bad = (funct3_d != 3'b000);
        word.reg_write  = 1'b1;
        word.alu_src    = 1'b1;
        word.jump       = 2'b10;
        word.result_src = 2'b10;
      end
      OP_LUI: begin
        ImmSrc_d = 3'b100;
        word.reg_write   = 1'b1;
        word.alu_src     = 1'b1;
        word.alu_control = ALU_PASSB;
      end
      OP_AUIPC: begin
        ImmSrc_d = 3'b100;
        word.reg_write = 1'b1;
        word.alu_src   = 1'b1;
        word.a_src_pc  = 1'b1;
      end
      default: begin
        bad = 1'b1;
      end
    endcase
    if (bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end else begin
      dec = word;
    end
  end

  assign illegal_d = bad;

  // ID/EX register: a flush overrides whatever ID decoded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex <= '0;
    end else if (flush_e) begin
      id_ex <= '0;
    end else begin
      id_ex <= dec;
    end
  end

  // EX/MEM register: free-running copy of the fields MEM and WB still need.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mem <= '0;
    end else begin
      ex_mem <= '{illegal: id_ex.illegal, reg_write: id_ex.reg_write,
                  result_src: id_ex.result_src, mem_write: id_ex.mem_write,
                  funct3: id_ex.funct3};
    end
  end

  // MEM/WB register: free-running copy of the write-back fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wb <= '0;
    end else begin
      mem_wb <= '{illegal: ex_mem.illegal, reg_write: ex_mem.reg_write,
                  result_src: ex_mem.result_src};
    end
  end

  // Branch condition for the conditional branch sitting in EX.
  always_comb begin
    cond = 1'b0;
    case (id_ex.funct3)
      3'b000:  cond = zero_e;
      3'b001:  cond = !zero_e;
      3'b100:  cond = lt_e;
      3'b101:  cond = !lt_e;
      3'b110:  cond = ltu_e;
      3'b111:  cond = !ltu_e;
      default: cond = 1'b0;
    endcase
  end

  // Next-PC select: a taken branch wins, otherwise the jump kind in EX.
  always_comb begin
    PCSrc_e = 2'b00;
    if (id_ex.branch && cond) begin
      PCSrc_e = 2'b01;
    end else begin
      PCSrc_e = id_ex.jump;
    end
  end

  assign taken_e             = (PCSrc_e != 2'b00);
  assign ALUControl_e        = id_ex.alu_control;
  assign ALUSrc_e            = id_ex.alu_src;
  assign ASrcPC_e            = id_ex.a_src_pc;
  assign MemRead_e           = id_ex.mem_read;
  assign MemWrite_m          = ex_mem.mem_write;
  assign AddressingControl_m = ADDR_W'(ex_mem.funct3);
  assign RegWrite_m          = ex_mem.reg_write;
  assign RegWrite_w          = mem_wb.reg_write;
  assign ResultSrc_w         = mem_wb.result_src;
  assign illegal_w           = mem_wb.illegal;

endmodule

// File: tb/tb_pipe_control.sv
// Directed testbench for pipe_control: a decode/EX vector table plus
// hand-written multi-cycle sequences for reset, flush, load-use and illegal ops.
module tb_pipe_control;

  logic       clk;
  logic       rst;
  logic [6:0] op_d;
  logic [2:0] funct3_d;
  logic [6:0] funct7_d;
  logic       flush_e, zero_e, lt_e, ltu_e;
  logic [2:0] ImmSrc_d;
  logic       illegal_d;
  logic [3:0] ALUControl_e;
  logic       ALUSrc_e, ASrcPC_e;
  logic [1:0] PCSrc_e;
  logic       taken_e, MemRead_e, MemWrite_m;
  logic [2:0] AddressingControl_m;
  logic       RegWrite_m, RegWrite_w;
  logic [1:0] ResultSrc_w;
  logic       illegal_w;

  int total = 0;
  int passed = 0;

  pipe_control #(.ALUCTRL_W(4), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .op_d(op_d), .funct3_d(funct3_d), .funct7_d(funct7_d),
    .flush_e(flush_e), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
    .ImmSrc_d(ImmSrc_d), .illegal_d(illegal_d), .ALUControl_e(ALUControl_e),
    .ALUSrc_e(ALUSrc_e), .ASrcPC_e(ASrcPC_e), .PCSrc_e(PCSrc_e), .taken_e(taken_e),
    .MemRead_e(MemRead_e), .MemWrite_m(MemWrite_m),
    .AddressingControl_m(AddressingControl_m), .RegWrite_m(RegWrite_m),
    .RegWrite_w(RegWrite_w), .ResultSrc_w(ResultSrc_w), .illegal_w(illegal_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z, lt, ltu;
    logic [2:0] imm;
    logic       ill;
    logic [3:0] alu;
    logic       alusrc, asrc;
    logic [1:0] pcsrc;
    logic       memread;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic z, input logic lt, input logic ltu,
                              input logic [2:0] imm, input logic ill, input logic [3:0] alu,
                              input logic alusrc, input logic asrc, input logic [1:0] pcsrc,
                              input logic memread);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.lt = lt; v.ltu = ltu;
    v.imm = imm; v.ill = ill; v.alu = alu; v.alusrc = alusrc; v.asrc = asrc;
    v.pcsrc = pcsrc; v.memread = memread;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    op_d = op; funct3_d = f3; funct7_d = f7;
  endtask

  initial begin
    // op, f3, f7, zero, lt, ltu | imm, ill, alu, alusrc, asrc, pcsrc, memread
    tbl[0]  = mk(7'b1100011, 3'b101, 7'h00, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 4'b0001, 1'b0, 1'b0, 2'b01, 1'b0); // bge !lt
    tbl[1]  = mk(7'b1100011, 3'b101, 7'h00, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 4'b0001, 1'b0, 1'b0, 2'b00, 1'b0); // bge lt
    tbl[2]  = mk(7'b1100011, 3'b110, 7'h00, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 4'b0001, 1'b0, 1'b0, 2'b01, 1'b0); // bltu ltu
    tbl[3]  = mk(7'b1100011, 3'b110, 7'h00, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 4'b0001, 1'b0, 1'b0, 2'b00, 1'b0); // bltu !ltu
    tbl[4]  = mk(7'b1100011, 3'b111, 7'h00, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 4'b0001, 1'b0, 1'b0, 2'b01, 1'b0); // bgeu !ltu
    tbl[5]  = mk(7'b1100011, 3'b111, 7'h00, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 4'b0001, 1'b0, 1'b0, 2'b00, 1'b0); // bgeu ltu
    tbl[6]  = mk(7'b1100011, 3'b000, 7'h00, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 4'b0001, 1'b0, 1'b0, 2'b01, 1'b0); // beq z
    tbl[7]  = mk(7'b1100011, 3'b000, 7'h00, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0, 4'b0001, 1'b0, 1'b0, 2'b00, 1'b0); // beq !z
    tbl[8]  = mk(7'b1100011, 3'b001, 7'h00, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 4'b0001, 1'b0, 1'b0, 2'b01, 1'b0); // bne !z
    tbl[9]  = mk(7'b1100011, 3'b001, 7'h00, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 4'b0001, 1'b0, 1'b0, 2'b00, 1'b0); // bne z
    tbl[10] = mk(7'b1100011, 3'b100, 7'h00, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 4'b0001, 1'b0, 1'b0, 2'b01, 1'b0); // blt lt
    tbl[11] = mk(7'b0110111, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 4'b1010, 1'b1, 1'b0, 2'b00, 1'b0); // lui
    tbl[12] = mk(7'b0010111, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 4'b0000, 1'b1, 1'b1, 2'b00, 1'b0); // auipc
    tbl[13] = mk(7'b0110011, 3'b010, 7'h00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'b0101, 1'b0, 1'b0, 2'b00, 1'b0); // slt
    tbl[14] = mk(7'b0010011, 3'b101, 7'h20, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'b1001, 1'b1, 1'b0, 2'b00, 1'b0); // srai
    tbl[15] = mk(7'b0000011, 3'b010, 7'h00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'b0000, 1'b1, 1'b0, 2'b00, 1'b1); // lw
    tbl[16] = mk(7'b1101111, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b01, 1'b0); // jal
    tbl[17] = mk(7'b0001111, 3'b000, 7'h00, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0); // illegal op
    tbl[18] = mk(7'b1100011, 3'b010, 7'h00, 1'b1, 1'b1, 1'b1, 3'b010, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0); // branch f3=010

    // Reset with sw sitting in ID.
    rst = 1'b1; flush_e = 1'b0; zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
    set_id(7'b0100011, 3'b010, 7'h00);
    step(); step();
    chk("rst_memwrite_m", {15'd0, MemWrite_m}, 16'd0);
    chk("rst_regwrite_w", {15'd0, RegWrite_w}, 16'd0);
    chk("rst_pcsrc", {14'd0, PCSrc_e}, 16'd0);
    chk("rst_immsrc_follows_op", {13'd0, ImmSrc_d}, 16'd1);
    rst = 1'b0;
    step();
    chk("sw_mem_not_yet", {15'd0, MemWrite_m}, 16'd0);
    flush_e = 1'b1;
    step();
    chk("sw_memwrite_2cyc", {12'd0, MemWrite_m, AddressingControl_m}, {12'd0, 1'b1, 3'b010});
    step();
    chk("sw_memwrite_drops", {15'd0, MemWrite_m}, 16'd0);
    step(); step();

    // Decode/EX table.
    flush_e = 1'b0;
    for (int i = 0; i < 19; i++) begin
      zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
      set_id(tbl[i].op, tbl[i].f3, tbl[i].f7);
      #1;
      chk($sformatf("vec%0d_id", i), {12'd0, ImmSrc_d, illegal_d}, {12'd0, tbl[i].imm, tbl[i].ill});
      step();
      zero_e = tbl[i].z; lt_e = tbl[i].lt; ltu_e = tbl[i].ltu;
      #1;
      chk($sformatf("vec%0d_ex", i),
          {6'd0, ALUControl_e, ALUSrc_e, ASrcPC_e, PCSrc_e, taken_e, MemRead_e},
          {6'd0, tbl[i].alu, tbl[i].alusrc, tbl[i].asrc, tbl[i].pcsrc,
           (tbl[i].pcsrc != 2'b00), tbl[i].memread});
    end
    zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;

    // Flush to clear, then jalr followed by add with flush while jalr is in EX.
    flush_e = 1'b1; step(); step(); step();
    flush_e = 1'b0;
    set_id(7'b1100111, 3'b000, 7'h00);
    step();
    set_id(7'b0110011, 3'b000, 7'h00);
    flush_e = 1'b1;
    #1;
    chk("jalr_pcsrc", {13'd0, PCSrc_e, taken_e}, {13'd0, 2'b10, 1'b1});
    step();
    flush_e = 1'b0;
    set_id(7'b0100011, 3'b000, 7'h00);
    chk("jalr_bubble_in_ex", {15'd0, ALUSrc_e}, 16'd0);
    step();
    chk("add_flushed_regwrite_m", {15'd0, RegWrite_m}, 16'd0);
    chk("jalr_wb", {13'd0, RegWrite_w, ResultSrc_w}, {13'd0, 1'b1, 2'b10});
    flush_e = 1'b1;
    step();
    chk("add_flushed_regwrite_w", {15'd0, RegWrite_w}, 16'd0);
    step(); step(); step();

    // Load-use: lw then stall bubble.
    flush_e = 1'b0;
    set_id(7'b0000011, 3'b010, 7'h00);
    step();
    chk("lw_memread_e", {15'd0, MemRead_e}, 16'd1);
    set_id(7'b0110011, 3'b000, 7'h00);
    flush_e = 1'b1;
    step();
    flush_e = 1'b0;
    set_id(7'b0100011, 3'b010, 7'h00);
    chk("loaduse_bubble_memread", {15'd0, MemRead_e}, 16'd0);
    step();
    chk("lw_wb", {13'd0, RegWrite_w, ResultSrc_w}, {13'd0, 1'b1, 2'b01});
    step();
    chk("loaduse_bubble_wb", {15'd0, RegWrite_w}, 16'd0);
    flush_e = 1'b1;
    step(); step(); step();

    // Illegal op travels to WB as a flagged bubble.
    flush_e = 1'b0;
    set_id(7'b0001111, 3'b000, 7'h00);
    #1;
    chk("illegal_d", {15'd0, illegal_d}, 16'd1);
    step();
    set_id(7'b0010011, 3'b000, 7'h00);
    chk("illegal_ex_enables", {13'd0, MemRead_e, PCSrc_e}, 16'd0);
    chk("illegal_w_1cyc", {15'd0, illegal_w}, 16'd0);
    step();
    chk("illegal_mem_enables", {14'd0, MemWrite_m, RegWrite_m}, 16'd0);
    chk("illegal_w_2cyc", {15'd0, illegal_w}, 16'd0);
    step();
    chk("illegal_w_3cyc", {14'd0, illegal_w, RegWrite_w}, {14'd0, 1'b1, 1'b0});
    step();
    chk("illegal_w_clears", {14'd0, illegal_w, RegWrite_w}, {14'd0, 1'b0, 1'b1});

    // Asynchronous reset mid-stream, between clock edges.
    set_id(7'b1100111, 3'b000, 7'h00);
    step();
    chk("pre_rst_inflight", {13'd0, RegWrite_m, PCSrc_e}, {13'd0, 1'b1, 2'b10});
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_drop", {7'd0, RegWrite_m, RegWrite_w, MemRead_e, ALUSrc_e, PCSrc_e, ALUControl_e},
        16'd0);
    #1;
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
